// File: rtl/ysyx_23060136_exu_div.sv
// ============================================================================
// Module   : ysyx_23060136_exu_div
// Brief    : Iterative radix-2 restoring divider for RV64M DIV/REM (and W forms).
// Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_23060136_exu_div #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             div_valid,
  input  logic             divw,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             div_ready,
  output logic             div_out_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int c_HALF  = WIDTH / 2;
  localparam int c_CNT_W = $clog2(WIDTH) + 1;

  localparam logic [WIDTH-1:0]  c_MIN_F   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [c_HALF-1:0] c_MIN_H   = {1'b1, {(c_HALF-1){1'b0}}};
  localparam logic [c_CNT_W-1:0] c_N_FULL = c_CNT_W'(WIDTH);
  localparam logic [c_CNT_W-1:0] c_N_HALF = c_CNT_W'(c_HALF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_ready;
  logic               r_out_valid;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_dsor;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_divw;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;

  function automatic logic [WIDTH-1:0] sext_half(input logic [c_HALF-1:0] v);
    return {{c_HALF{v[c_HALF-1]}}, v};
  endfunction

  // Effective operands after word selection and sign/zero extension
  logic [WIDTH-1:0] w_a_eff;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic             w_div0;
  logic             w_ovf;
  logic [WIDTH-1:0] w_a_wext;

  always_comb begin
    w_a_eff  = divw ? {{c_HALF{div_signed & dividend[c_HALF-1]}}, dividend[c_HALF-1:0]}
                    : dividend;
    w_b_eff  = divw ? {{c_HALF{div_signed & divisor[c_HALF-1]}}, divisor[c_HALF-1:0]}
                    : divisor;
    w_a_neg  = div_signed & w_a_eff[WIDTH-1];
    w_b_neg  = div_signed & w_b_eff[WIDTH-1];
    w_a_abs  = w_a_neg ? (~w_a_eff + 1'b1) : w_a_eff;
    w_b_abs  = w_b_neg ? (~w_b_eff + 1'b1) : w_b_eff;
    w_div0   = (w_b_eff == '0);
    w_ovf    = div_signed && (w_b_eff == '1) &&
               (divw ? (w_a_eff[c_HALF-1:0] == c_MIN_H) : (w_a_eff == c_MIN_F));
    w_a_wext = divw ? sext_half(dividend[c_HALF-1:0]) : dividend;
  end

  // One restoring step; the difference's top bit is the borrow
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quot_nx;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic [WIDTH-1:0] w_q_res;
  logic [WIDTH-1:0] w_r_res;

  always_comb begin
    w_shift   = {r_rem, r_quot[WIDTH-1]};
    w_diff    = w_shift - {1'b0, r_dsor};
    w_ge      = ~w_diff[WIDTH];
    w_rem_nx  = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    w_quot_nx = {r_quot[WIDTH-2:0], w_ge};
    w_q_fix   = r_neg_q ? (~w_quot_nx + 1'b1) : w_quot_nx;
    w_r_fix   = r_neg_r ? (~w_rem_nx + 1'b1) : w_rem_nx;
    w_q_res   = r_divw ? sext_half(w_q_fix[c_HALF-1:0]) : w_q_fix;
    w_r_res   = r_divw ? sext_half(w_r_fix[c_HALF-1:0]) : w_r_fix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b1;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quot      <= '0;
      r_dsor      <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_divw      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
        r_ready <= 1'b1;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (div_valid) begin
              r_ready <= 1'b0;
              r_divw  <= divw;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_dsor  <= w_b_abs;
              r_rem   <= '0;
              // Word ops pre-align the dividend so 32 shifts consume it fully
              r_quot  <= divw ? {w_a_abs[c_HALF-1:0], {c_HALF{1'b0}}} : w_a_abs;
              if (w_div0) begin
                r_state     <= S_DONE;
                r_out_valid <= 1'b1;
                r_quotient  <= '1;
                r_remainder <= w_a_wext;
              end else if (w_ovf) begin
                r_state     <= S_DONE;
                r_out_valid <= 1'b1;
                r_quotient  <= w_a_wext;
                r_remainder <= '0;
              end else begin
                r_state <= S_BUSY;
                r_cnt   <= divw ? c_N_HALF : c_N_FULL;
              end
            end
          end
          S_BUSY: begin
            r_rem  <= w_rem_nx;
            r_quot <= w_quot_nx;
            r_cnt  <= r_cnt - 1'b1;
            if (r_cnt == c_CNT_W'(1)) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_quotient  <= w_q_res;
              r_remainder <= w_r_res;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
          default: begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign div_ready     = r_ready;
  assign div_out_valid = r_out_valid;
  assign quotient      = r_quotient;
  assign remainder     = r_remainder;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060136_exu_div.sv
// ============================================================================
// Module   : tb_ysyx_23060136_exu_div
// Brief    : Directed vector bench for the iterative RV64M divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_23060136_exu_div;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        div_valid;
  logic        divw;
  logic        div_signed;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        div_ready;
  logic        div_out_valid;
  logic [63:0] quotient;
  logic [63:0] remainder;

  int checks;
  int failures;

  ysyx_23060136_exu_div #(.WIDTH(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .div_valid    (div_valid),
    .divw         (divw),
    .div_signed   (div_signed),
    .dividend     (dividend),
    .divisor      (divisor),
    .div_ready    (div_ready),
    .div_out_valid(div_out_valid),
    .quotient     (quotient),
    .remainder    (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic        sgn;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and check latency, results and single-cycle pulse
  task automatic do_div(input string name, input logic w, input logic sgn,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] eq, input logic [63:0] er,
                        input int elat, input logic hold);
    int n;
    int lat;
    n = 0;
    while (!div_ready && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_ready"}, {63'd0, div_ready}, 64'd1);
    divw       = w;
    div_signed = sgn;
    dividend   = a;
    divisor    = b;
    div_valid  = 1'b1;
    tick();
    if (!hold) div_valid = 1'b0;
    lat = 1;
    while (!div_out_valid && lat < 200) begin
      if (hold && lat == 10) chk({name, "_busy_ready"}, {63'd0, div_ready}, 64'd0);
      tick();
      lat++;
    end
    div_valid = 1'b0;
    chk({name, "_lat"}, 64'(lat), 64'(elat));
    chk({name, "_q"}, quotient, eq);
    chk({name, "_r"}, remainder, er);
    tick();
    chk({name, "_pulse_end"}, {63'd0, div_out_valid}, 64'd0);
  endtask

  initial begin
    int seen;
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    flush      = 1'b0;
    div_valid  = 1'b0;
    divw       = 1'b0;
    div_signed = 1'b0;
    dividend   = '0;
    divisor    = '0;

    vecs[0]  = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[1]  = '{1'b1, 1'b0, 64'h1234_5678_FFFF_FFFE, 64'd3,
                 64'h0000_0000_5555_5554, 64'd2, 33};
    vecs[2]  = '{1'b0, 1'b1, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd100, 1};
    vecs[3]  = '{1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'h8000_0000_0000_0000, 64'd0, 1};
    vecs[4]  = '{1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'hFFFF_FFFF_8000_0000, 64'd0, 1};
    vecs[5]  = '{1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65};
    vecs[6]  = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
                 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 65};
    vecs[7]  = '{1'b0, 1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
                 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65};
    vecs[8]  = '{1'b1, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,
                 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    vecs[9]  = '{1'b1, 1'b0, 64'h0000_0000_8000_0005, 64'h0000_0001_0000_0000,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0005, 1};
    vecs[10] = '{1'b0, 1'b0, 64'd5, 64'd9, 64'd0, 64'd5, 65};
    vecs[11] = '{1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'd0, 64'h8000_0000_0000_0000, 65};
    vecs[12] = '{1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 33};

    repeat (3) tick();
    chk("rst_ready", {63'd0, div_ready}, 64'd1);
    chk("rst_valid", {63'd0, div_out_valid}, 64'd0);
    chk("rst_q", quotient, 64'd0);
    chk("rst_r", remainder, 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      do_div($sformatf("v%0d", i), vecs[i].w, vecs[i].sgn, vecs[i].a, vecs[i].b,
             vecs[i].q, vecs[i].r, vecs[i].lat, 1'b0);
    end

    // div_valid held through BUSY must not restart the operation
    do_div("hold", 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h10,
           64'h07FF_FFFF_FFFF_FFFF, 64'hF, 65, 1'b1);

    // Flush mid-division, then a fresh request right away
    seen       = 0;
    divw       = 1'b0;
    div_signed = 1'b0;
    dividend   = 64'd1000;
    divisor    = 64'd7;
    div_valid  = 1'b1;
    tick();
    div_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (div_out_valid) seen++;
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    if (div_out_valid) seen++;
    chk("flush_no_pulse", 64'(seen), 64'd0);
    chk("flush_ready", {63'd0, div_ready}, 64'd1);
    do_div("after_flush", 1'b0, 1'b0, 64'd9, 64'd3, 64'd3, 64'd0, 65, 1'b0);

    // Flush together with div_valid in IDLE: a div-by-zero would pulse next cycle
    dividend  = 64'd5;
    divisor   = 64'd0;
    div_valid = 1'b1;
    flush     = 1'b1;
    tick();
    div_valid = 1'b0;
    flush     = 1'b0;
    chk("idle_flush_valid0", {63'd0, div_out_valid}, 64'd0);
    chk("idle_flush_ready", {63'd0, div_ready}, 64'd1);
    tick();
    chk("idle_flush_valid1", {63'd0, div_out_valid}, 64'd0);

    // Flush in the DONE cycle keeps that pulse
    div_valid = 1'b1;
    tick();
    div_valid = 1'b0;
    chk("done_flush_pulse", {63'd0, div_out_valid}, 64'd1);
    chk("done_flush_q", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("done_flush_after", {63'd0, div_out_valid}, 64'd0);
    chk("done_flush_ready", {63'd0, div_ready}, 64'd1);

    // Reset in the middle of a division
    dividend  = 64'd100;
    divisor   = 64'd7;
    div_valid = 1'b1;
    tick();
    for (int k = 0; k < 19; k++) tick();
    chk("mid_busy_ready", {63'd0, div_ready}, 64'd0);
    rst       = 1'b1;
    div_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("mid_rst_ready", {63'd0, div_ready}, 64'd1);
    chk("mid_rst_valid", {63'd0, div_out_valid}, 64'd0);
    chk("mid_rst_q", quotient, 64'd0);
    chk("mid_rst_r", remainder, 64'd0);
    do_div("post_rst", 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
